// File: rtl/fracnet_div_pkg.sv
// Shared types and constants for the FracNet sequential signed divider.
// Optional feature macro: FRACNET_DIV_REM_EN (adds the signed remainder output).
package fracnet_div_pkg;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 8;
    localparam int QUOT_W     = 16;

    // Counter must be able to hold DIVIDEND_W itself (end-of-CALC marker).
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    localparam logic signed [QUOT_W-1:0] QMAX = 16'sh7FFF;
    localparam logic signed [QUOT_W-1:0] QMIN = 16'sh8000;

    // Largest quotient magnitudes that fit the output without saturating.
    localparam logic [DIVIDEND_W-1:0] MAG_POS_MAX = 24'd32767;
    localparam logic [DIVIDEND_W-1:0] MAG_NEG_MAX = 24'd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fracnet_t_div_seq_24s_8s_16_if.sv
// Handshake/data bundle for the sequential divider.
// Optional feature macro: FRACNET_DIV_REM_EN (adds rem to the bundle).
//
// Handshake: a transfer happens on a rising clk edge where ce=1 and both
// valid and ready are high. The source holds valid and data steady until
// that edge; the divider only raises in_ready in IDLE and holds out_valid
// plus all result fields stable until the result is taken.
interface fracnet_t_div_seq_24s_8s_16_if;
    import fracnet_div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quot;
    logic                  ovf;
    logic                  dz;
`ifdef FRACNET_DIV_REM_EN
    logic [DIVISOR_W-1:0]  rem;
`endif

`ifdef FRACNET_DIV_REM_EN
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, ovf, dz, rem
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, ovf, dz, rem
    );
`else
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, ovf, dz
    );
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, ovf, dz
    );
`endif

endinterface

// File: rtl/fracnet_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder, trial-subtract
// the divisor, keep the difference when it does not go negative.
module fracnet_div_step
    import fracnet_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_prem,
    input  logic [DIVISOR_W-1:0] i_dvsr,
    input  logic                 i_bit,
    output logic [DIVISOR_W-1:0] o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W-1:0] w_diff;

    assign w_shift = {i_prem, i_bit};
    // Low bits of the difference are all that survive a successful subtract.
    assign w_diff  = w_shift[DIVISOR_W-1:0] - i_dvsr;
    assign o_qbit  = (w_shift >= {1'b0, i_dvsr});
    assign o_prem  = o_qbit ? w_diff : w_shift[DIVISOR_W-1:0];

endmodule

// File: rtl/fracnet_t_div_seq_24s_8s_16.sv
// Sequential signed divider: 24s / 8s -> saturated 16s quotient, one
// quotient bit per ce-cycle, constant 26 ce-cycle latency (divide by zero too).
// Optional feature macro: FRACNET_DIV_REM_EN (exposes the signed remainder).
module fracnet_t_div_seq_24s_8s_16
    import fracnet_div_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ce,
    fracnet_t_div_seq_24s_8s_16_if.slave    bus,
    output logic [1:0]                      o_dbg_state
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_acc;     // dividend bits shift out the top, quotient bits in the bottom
    logic [DIVISOR_W-1:0]  r_prem;
    logic [DIVISOR_W-1:0]  r_dvsr;
    logic                  r_sd;
    logic                  r_sv;
    logic                  r_dz_op;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [QUOT_W-1:0]     r_quot;
    logic                  r_ovf;
    logic                  r_dz;
`ifdef FRACNET_DIV_REM_EN
    logic [DIVISOR_W-1:0]  r_rem;
`endif

    logic [DIVISOR_W-1:0]  w_prem;
    logic                  w_qbit;
    logic                  w_neg;
    logic [QUOT_W-1:0]     w_quot;
    logic                  w_ovf;
    logic [DIVISOR_W-1:0]  w_rem;

    fracnet_div_step u_step (
        .i_prem (r_prem),
        .i_dvsr (r_dvsr),
        .i_bit  (r_acc[DIVIDEND_W-1]),
        .o_prem (w_prem),
        .o_qbit (w_qbit)
    );

    assign w_neg = r_sd ^ r_sv;

    // Sign fix-up and saturation of the unsigned quotient magnitude.
    always_comb begin
        w_quot = '0;
        w_ovf  = 1'b0;
        w_rem  = '0;
        if (r_dz_op) begin
            w_quot = r_sd ? QMIN : QMAX;
        end else begin
            w_rem = r_sd ? (~r_prem + 1'b1) : r_prem;
            if (w_neg) begin
                if (r_acc > MAG_NEG_MAX) begin
                    w_quot = QMIN;
                    w_ovf  = 1'b1;
                end else begin
                    w_quot = ~r_acc[QUOT_W-1:0] + 1'b1;
                end
            end else begin
                if (r_acc > MAG_POS_MAX) begin
                    w_quot = QMAX;
                    w_ovf  = 1'b1;
                end else begin
                    w_quot = r_acc[QUOT_W-1:0];
                end
            end
        end
    end

    // Control FSM, iteration counter, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_prem      <= '0;
            r_dvsr      <= '0;
            r_sd        <= 1'b0;
            r_sv        <= 1'b0;
            r_dz_op     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
`ifdef FRACNET_DIV_REM_EN
            r_rem       <= '0;
`endif
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sd       <= bus.dividend[DIVIDEND_W-1];
                        r_sv       <= bus.divisor[DIVISOR_W-1];
                        r_acc      <= bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
                        r_dvsr     <= bus.divisor[DIVISOR_W-1] ? (~bus.divisor + 1'b1) : bus.divisor;
                        r_dz_op    <= (bus.divisor == '0);
                        r_prem     <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == CNT_W'(DIVIDEND_W)) begin
                        r_state <= FIX;
                    end else begin
                        r_acc  <= {r_acc[DIVIDEND_W-2:0], w_qbit};
                        r_prem <= w_prem;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                FIX: begin
                    r_quot      <= w_quot;
                    r_ovf       <= w_ovf;
                    r_dz        <= r_dz_op;
`ifdef FRACNET_DIV_REM_EN
                    r_rem       <= w_rem;
`endif
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.quot      = r_quot;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;
`ifdef FRACNET_DIV_REM_EN
    assign bus.rem       = r_rem;
`endif
    assign o_dbg_state   = r_state;

endmodule
